img_rom_arbiter: RTL
====================

IMG_ROM_ARBITER -- requirements
Module: img_rom_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- NUM_REQ, 4, number of requesters.
- ADDR_W, 17, ROM address width.
- DATA_W, 12, ROM pixel data width (RGB444).
- ROM_LAT, 1, ROM read latency in cycles, range 1..4.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports (name, direction, width, meaning):
- clk, in, 1, clock (25 MHz pixel clock domain).
- rst, in, 1, asynchronous active-low reset.
- flush, in, 1, scene-change flush; drops in-flight responses.
- prio_en, in, 1, requester 0 (display pipeline) gets strict priority.
- req, in, NUM_REQ, per-requester read request, level.
- req_addr, in, NUM_REQ*ADDR_W, flattened addresses; slice i belongs to requester i.
- gnt, out, NUM_REQ, one-hot grant pulse.
- rom_addr, out, ADDR_W, address to the shared ROM port.
- rom_data, in, DATA_W, ROM read data.
- rvalid, out, NUM_REQ, one-hot response-valid pulse.
- rdata, out, DATA_W, response data, shared by all requesters.
- busy, out, 1, at least one read is in flight.

Function
REQ-003 The block SHALL evaluate req every cycle and register at most one grant per cycle; gnt[i] SHALL be high for exactly one cycle, in the cycle after sampling.
REQ-004 rom_addr SHALL be registered and SHALL equal the granted requester's address in the same cycle gnt is high; it SHALL hold its last value when there is no grant.
REQ-005 Arbitration SHALL be round-robin. The search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0.
REQ-006 When prio_en=1 and req[0]=1, requester 0 SHALL win regardless of the round-robin pointer. The pointer SHALL NOT advance on such a grant.
REQ-007 A requester SHALL hold req and its address stable until it sees gnt. It MAY deassert req or keep it asserted for back-to-back reads. The arbiter SHALL NOT grant a requester whose req is low.
REQ-008 A tag pipeline of depth ROM_LAT SHALL carry the one-hot grant. rvalid[i] SHALL assert exactly ROM_LAT cycles after gnt[i], with rdata = rom_data registered in that cycle. Total latency from req sampling to rvalid is ROM_LAT+1 cycles.
REQ-009 Throughput SHALL be one read per cycle when requests are continuous. No bubbles are allowed between grants.
REQ-010 flush=1 SHALL clear every tag pipeline stage and the pending grant in the same edge. No rvalid may appear for reads granted before or during the flush cycle. Arbitration SHALL resume the cycle after flush deasserts. The round-robin pointer SHALL reset to 0.
REQ-011 busy SHALL be the OR of the grant register and all tag stages.
REQ-012 If req is all zero, the arbiter SHALL issue no grant and SHALL leave the pointer unchanged.
REQ-013 If all requesters assert req simultaneously (prio_en=0), grants SHALL rotate 0,1,2,3,0,... starting from the pointer after reset.
REQ-014 rdata SHALL hold its last value when rvalid is all zero.

Reset
REQ-015 When rst=0, the block SHALL asynchronously set:
- gnt, rvalid, busy and all tag stages to 0.
- rom_addr and rdata to 0.
- the round-robin pointer to NUM_REQ-1, so requester 0 wins first.
REQ-016 Reset asserted mid-read SHALL discard the in-flight read with no rvalid afterward. Deassertion SHALL be synchronized so that the first grant occurs no earlier than the second clk edge after rst rises.

Structure
REQ-017 A shared package SHALL hold IMG_ADDR_W=17, IMG_DATA_W=12 and the scene_state encodings (START=4'b0001, CHOOSE=4'b0010, FIGHT=4'b0011, WIN=4'b0100). The scene encodings are for the flush-generation logic in the top level.
REQ-018 The round-robin selection (request vector, pointer, priority bit -> one-hot winner) SHALL be a separate combinational sub-module, rr_pick.
REQ-019 One arbiter instance SHALL be placed per image ROM (title, poke, alpha). This replaces the current per-scene address selection.

Verification
REQ-020 Scenario 1, single read: ROM_LAT=1, req=4'b0010, addr1=0x00123, ROM returns 0xABC -> gnt=4'b0010 at cycle 1, rom_addr=0x00123 at cycle 1, rvalid=4'b0010 and rdata=0xABC at cycle 2.
REQ-021 Scenario 2, full contention: req=4'b1111 held 8 cycles, prio_en=0 -> gnt sequence 0,1,2,3,0,1,2,3 with no idle cycles, and 8 rvalid pulses in matching order.
REQ-022 Scenario 3, priority: prio_en=1, req=4'b1111 held, req[0] dropped after 3 grants -> gnts 0,0,0 then 1,2,3 (pointer unmoved by the priority grants).
REQ-023 Scenario 4, flush: ROM_LAT=3, grants to 2 then 3, flush pulsed on the cycle after gnt[3] -> zero rvalid pulses; the next grant to 0 yields rvalid 4 cycles after req.
REQ-024 Scenario 5, reset mid-operation: rst low for 2 cycles while 2 reads are in flight -> all outputs 0 during reset, no stale rvalid afterward, first grant to requester 0.

Source files
------------

// File: rtl/img_rom_arbiter_pkg.sv
// Shared definitions for the image ROM arbiters.
//   IMG_ADDR_W / IMG_DATA_W : default image ROM address and pixel (RGB444) widths.
//   scene_state_e           : scene encodings used by the top-level flush generation.
//   oh2idx                  : one-hot to index helper (inputs up to 32 bits wide).
package img_rom_arbiter_pkg;

    localparam int unsigned IMG_ADDR_W = 17;
    localparam int unsigned IMG_DATA_W = 12;

    typedef enum logic [3:0] {
        START  = 4'b0001,
        CHOOSE = 4'b0010,
        FIGHT  = 4'b0011,
        WIN    = 4'b0100
    } scene_state_e;

    // Index of the highest set bit; a one-hot input has only one.
    function automatic int unsigned oh2idx(input logic [31:0] oh);
        oh2idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) oh2idx = i;
        end
    endfunction

endpackage

// File: rtl/img_rom_arbiter_if.sv
// Requester-side bus of the image ROM arbiter.
//   req      : per-requester level read request
//   req_addr : flattened addresses, slice i belongs to requester i
//   gnt      : one-hot grant pulse
//   rvalid   : one-hot response-valid pulse
//   rdata    : response data shared by all requesters
// master = requester side, slave = arbiter side.
interface img_rom_arbiter_if
    import img_rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = IMG_ADDR_W,
    parameter int unsigned DATA_W  = IMG_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (output req, output req_addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input req_addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/img_rom_arbiter_rr_pick.sv
// Combinational round-robin winner selection.
//   req  : request vector
//   ptr  : index of the last round-robin winner; search starts at ptr+1 and wraps
//   prio : when set and req[0] is high, requester 0 wins outright
//   win  : one-hot winner, all zero when req is all zero
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               prio,
    output logic [NUM_REQ-1:0] win
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        win = '0;
        idx = '0;
        if (prio && req[0]) begin
            win[0] = 1'b1;
        end else begin
            // k = NUM_REQ visits ptr itself last, so a lone requester at ptr still wins.
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
                if (win == '0 && req[idx]) win[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/img_rom_arbiter.sv
// Round-robin arbiter sharing one image ROM port between NUM_REQ requesters.
//   clk, rst  : clock, asynchronous active-low reset
//   flush     : scene-change flush, drops every in-flight response
//   prio_en   : requester 0 gets strict priority
//   bus       : requester bus (req/req_addr in, gnt/rvalid/rdata out)
//   rom_addr  : registered address to the shared ROM
//   rom_data  : ROM read data, captured ROM_LAT cycles after the grant
//   busy      : a grant or a response is still in flight
module img_rom_arbiter
    import img_rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = IMG_ADDR_W,
    parameter int unsigned DATA_W  = IMG_DATA_W,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                prio_en,
    img_rom_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                busy
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]         rst_sync_q;
    logic               run;
    logic [NUM_REQ-1:0] win, gnt_d, gnt_q;
    logic [IDX_W-1:0]   win_idx, ptr_d, ptr_q;
    logic               prio_hit;
    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
    logic [DATA_W-1:0]  rdata_d, rdata_q;
    logic [NUM_REQ-1:0] tag_in [ROM_LAT];
    logic [NUM_REQ-1:0] tag_d  [ROM_LAT];
    logic [NUM_REQ-1:0] tag_q  [ROM_LAT];
    logic               busy_c;

    // Reset asserts immediately but releases arbitration only after two clean edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .prio (prio_en),
        .win  (win)
    );

    always_comb begin
        gnt_d      = '0;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        win_idx    = IDX_W'(oh2idx(32'(win)));
        prio_hit   = prio_en && bus.req[0];
        if (run && !flush) gnt_d = win;
        if (flush) begin
            ptr_d = '0;
        end else if (gnt_d != '0) begin
            rom_addr_d = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            // Priority grants leave the rotation where it was.
            if (!prio_hit) ptr_d = win_idx;
        end
    end

    // Tag pipeline: stage 0 follows the grant, the last stage is rvalid.
    always_comb begin
        tag_in[0] = gnt_q;
        for (int unsigned k = 1; k < ROM_LAT; k++) tag_in[k] = tag_q[k-1];
        for (int unsigned k = 0; k < ROM_LAT; k++) tag_d[k] = flush ? '0 : tag_in[k];
        rdata_d = rdata_q;
        // Capture only alongside a surviving rvalid so rdata otherwise holds.
        if (!flush && tag_in[ROM_LAT-1] != '0) rdata_d = rom_data;
        busy_c = |gnt_q;
        for (int unsigned k = 0; k < ROM_LAT; k++) busy_c = busy_c | (|tag_q[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q      <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            rom_addr_q <= '0;
            rdata_q    <= '0;
            for (int unsigned k = 0; k < ROM_LAT; k++) tag_q[k] <= '0;
        end else begin
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            for (int unsigned k = 0; k < ROM_LAT; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = tag_q[ROM_LAT-1];
    assign bus.rdata  = rdata_q;
    assign rom_addr   = rom_addr_q;
    assign busy       = busy_c;
endmodule
